beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
Records a timed sequence of key presses (7-bit ASCII note codes) into on-chip memory and plays it back. Drives the note-code input of the existing tone generator (rate_divider / rate_divider_no_display). Owns the time base, so a recorded beat replays with the same note order and durations (tick resolution). Sits between the keyboard decoder and the tone generator; the top level selects live vs. playback.

Parameters:
DEPTH, 64, number of note entries in the sequence memory (power of 2)
ADDR_W, 6, log2(DEPTH)
DUR_W, 12, duration field width in ticks
TICK_DIV, 500000, clk cycles per tick (10 ms at 50 MHz); minimum 2

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
record_start  in  1  single-cycle pulse: start a new recording (discards the old one)
play_start  in  1  single-cycle pulse: play back the stored sequence
stop  in  1  single-cycle pulse: end recording or playback
key_valid  in  1  level: a key is currently held
key_ascii  in  7  ASCII code of the held key (meaningful only when key_valid=1)
note_ascii  out  7  note code to the tone generator; 0 = silence
note_active  out  1  1 when note_ascii is a real note (speaker enable)
mode  out  2  0=IDLE, 1=RECORD, 2=PLAY
count  out  ADDR_W+1  number of valid entries stored (0..DEPTH)
full  out  1  sticky: last recording stopped on memory full
done  out  1  one-cycle pulse when playback finishes or is stopped

Behaviour:
- Reset (async): mode=IDLE, note_ascii=0, note_active=0, count=0, full=0, done=0, prescaler=0. Memory contents are don't-care.
- Entry format: {ascii[6:0], dur[DUR_W-1:0]}. ascii=0 encodes a rest.
- Tick: prescaler counts 0..TICK_DIV-1 and emits tick when at TICK_DIV-1. It is cleared to 0 on every entry to RECORD or PLAY and held at 0 in IDLE.
- Command priority per cycle: stop > record_start > play_start. Starts are ignored outside IDLE. stop in IDLE is a no-op.
- IDLE: note_ascii=0, note_active=0.
- record_start -> RECORD next cycle. Set count=0 and full=0. Open a segment with seg_ascii = key_valid ? key_ascii : 0 and seg_dur=0.
- RECORD:
  - note_ascii = key_valid ? key_ascii : 0 (live monitor). note_active=key_valid.
  - Each tick increments seg_dur.
  - Segment close: the current code (key_valid ? key_ascii : 0) differs from seg_ascii, or seg_dur reaches 2^DUR_W-1.
  - On close, if seg_dur>0: write the entry at address count and increment count. If seg_dur=0, discard it (blip shorter than a tick).
  - A new segment opens in the same cycle with the current code and seg_dur=0. A saturation close reopens with the same code.
  - Write that makes count=DEPTH: set full=1 and go to IDLE next cycle.
  - stop: flush the open segment under the same seg_dur>0 rule (only if count<DEPTH), then go to IDLE.
  - A close and a tick in the same cycle: the tick is counted into the closing segment.
- play_start with count=0: done pulses next cycle and mode stays IDLE.
- play_start with count>0 -> PLAY:
  - Memory read is synchronous (1-cycle latency). Entry 0 is fetched first.
  - note_ascii becomes entry0.ascii exactly 2 cycles after the play_start cycle. The prescaler restarts at that same cycle.
  - Each entry is presented for exactly dur ticks = dur*TICK_DIV cycles.
  - Entry i+1 is prefetched while entry i plays. note_ascii switches in the cycle after the tick that expires entry i, with no gap cycle.
  - note_active = (note_ascii != 0).
  - After the last entry (index count-1) expires: note_ascii=0, done=1 for 1 cycle, mode=IDLE.
  - stop in PLAY: same exit (note_ascii=0, done pulse, IDLE) on the next cycle.
- count and stored entries persist across playbacks until the next record_start or reset.
- Async reset in RECORD or PLAY: immediate return to the reset state. Any partially recorded sequence is lost (count=0).

Test Plan:
- TICK_DIV=4. record_start; hold 'A'(65) 12 cycles, release 8 cycles, hold 'S'(83) 8 cycles; stop -> count=3, entries {65,3},{0,2},{83,2}.
- Play that recording -> note_ascii=65 for 12 cycles starting 2 cycles after play_start, then 0 for 8, then 83 for 8. Then done pulse, mode=0, note_active tracks nonzero.
- Record a key change with a 2-cycle blip of 'W'(87) between 'A' segments -> blip entry discarded. Adjacent 'A' segments stay separate entries. count matches.
- DEPTH=4. Alternate keys every 4 ticks -> after the 4th write full=1 and mode returns to IDLE without stop. Further key changes write nothing.
- play_start with count=0 -> done pulse in the next cycle and mode stays 0. record_start during PLAY is ignored. stop mid-PLAY -> note_ascii=0 and done next cycle.
- Assert reset mid-RECORD and mid-PLAY -> all outputs at reset values immediately. A following play_start gives an immediate done.

Source files
------------

// File: rtl/beat_sequencer.sv
// Records timed key-press segments into a small RAM and replays them with the
// same note order and tick-resolution durations, driving the tone generator.
module beat_sequencer #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              key_valid,
  input  logic [6:0]        key_ascii,
  output logic [6:0]        note_ascii,
  output logic              note_active,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = ADDR_W + 1;
  localparam int EW = 7 + DUR_W;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]    LAST_C    = CW'(DEPTH - 1);

  // FETCH is the one-cycle wait for entry 0 to come out of the RAM.
  typedef enum logic [1:0] {S_IDLE, S_REC, S_FETCH, S_PLAY} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               done_q, done_d;
  logic [6:0]         note_q, note_d;
  logic [6:0]         seg_ascii_q, seg_ascii_d;
  logic [DUR_W-1:0]   seg_dur_q, seg_dur_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [CW-1:0]      ptr_q, ptr_d;

  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      rdata_q;
  logic [ADDR_W-1:0]  raddr;
  logic               we;
  logic [EW-1:0]      wdata;

  logic               tick;
  logic [6:0]         cur_code;
  logic [DUR_W-1:0]   dur_eff;
  logic               seg_close;

  assign tick      = (state_q == S_REC || state_q == S_PLAY) && (presc_q == PRESC_MAX);
  assign cur_code  = key_valid ? key_ascii : 7'd0;
  // A tick landing on the closing cycle belongs to the closing segment.
  assign dur_eff   = seg_dur_q + {{(DUR_W-1){1'b0}}, tick};
  assign seg_close = (cur_code != seg_ascii_q) || (dur_eff == DUR_MAX);
  assign wdata     = {seg_ascii_q, dur_eff};

  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    count_d     = count_q;
    full_d      = full_q;
    done_d      = 1'b0;
    note_d      = note_q;
    seg_ascii_d = seg_ascii_q;
    seg_dur_d   = seg_dur_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    raddr       = ptr_q[ADDR_W-1:0];
    we          = 1'b0;

    if (state_q == S_REC || state_q == S_PLAY)
      presc_d = tick ? '0 : presc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        note_d = 7'd0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (record_start) begin
          state_d     = S_REC;
          count_d     = '0;
          full_d      = 1'b0;
          seg_ascii_d = cur_code;
          seg_dur_d   = '0;
        end else if (play_start) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            ptr_d   = '0;
            raddr   = '0;
          end
        end
      end

      S_REC: begin
        if (stop) begin
          state_d = S_IDLE;
          if (dur_eff != '0 && count_q != DEPTH_C) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == LAST_C) full_d = 1'b1;
          end
        end else if (seg_close) begin
          // Segments that never saw a tick are key-bounce blips; drop them.
          if (dur_eff != '0) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == LAST_C) begin
              full_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
          seg_ascii_d = cur_code;
          seg_dur_d   = '0;
        end else begin
          seg_dur_d = dur_eff;
        end
      end

      S_FETCH: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          note_d  = rdata_q[EW-1:DUR_W];
          rem_d   = rdata_q[DUR_W-1:0];
          ptr_d   = CW'(1);
          raddr   = ADDR_W'(1);
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (stop) begin
          note_d  = 7'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tick) begin
          if (rem_q <= DUR_ONE) begin
            // rdata_q already holds the prefetched entry ptr_q.
            if (ptr_q == count_q) begin
              note_d  = 7'd0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              note_d = rdata_q[EW-1:DUR_W];
              rem_d  = rdata_q[DUR_W-1:0];
              ptr_d  = ptr_q + 1'b1;
              raddr  = ADDR_W'(ptr_q + 1'b1);
            end
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      note_q      <= 7'd0;
      seg_ascii_q <= 7'd0;
      seg_dur_q   <= '0;
      rem_q       <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      full_q      <= full_d;
      done_q      <= done_d;
      note_q      <= note_d;
      seg_ascii_q <= seg_ascii_d;
      seg_dur_q   <= seg_dur_d;
      rem_q       <= rem_d;
      ptr_q       <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[count_q[ADDR_W-1:0]] <= wdata;
    rdata_q <= mem[raddr];
  end

  always_comb begin
    mode = 2'd0;
    case (state_q)
      S_REC:           mode = 2'd1;
      S_FETCH, S_PLAY: mode = 2'd2;
      default:         mode = 2'd0;
    endcase
  end

  // While recording, the speaker follows the keyboard directly.
  assign note_ascii  = (state_q == S_REC) ? cur_code : note_q;
  assign note_active = (state_q == S_REC) ? key_valid : (note_q != 7'd0);
  assign count       = count_q;
  assign full        = full_q;
  assign done        = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their spacing
// in cycles; a monitor compares every observed output change against the queue.
module tb_beat_sequencer;

  logic       clk;
  logic       reset;
  logic       record_start, play_start, stop, key_valid;
  logic [6:0] key_ascii;
  logic [6:0] note_ascii;
  logic       note_active;
  logic [1:0] mode;
  logic [2:0] count;
  logic       full, done;

  beat_sequencer #(.DEPTH(4), .ADDR_W(2), .DUR_W(12), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .record_start(record_start), .play_start(play_start),
    .stop(stop), .key_valid(key_valid), .key_ascii(key_ascii),
    .note_ascii(note_ascii), .note_active(note_active), .mode(mode),
    .count(count), .full(full), .done(done)
  );

  typedef struct packed {
    logic [1:0] m;
    logic [6:0] nt;
    logic       act;
    logic [2:0] cnt;
    logic       fl;
    logic       dn;
  } obs_t;

  typedef struct {
    obs_t o;
    int   gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Any change of the visible output tuple is an event and must match the queue.
  initial begin
    obs_t cur, prev;
    exp_t e;
    int   last;
    bit   first;
    first = 1'b1;
    prev  = '0;
    last  = 0;
    forever begin
      @(negedge clk);
      cur = '{m: mode, nt: note_ascii, act: note_active, cnt: count, fl: full, dn: done};
      if (first || cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got m=%0d note=%0d act=%0d cnt=%0d full=%0d done=%0d, expected no change",
                   cyc, cur.m, cur.nt, cur.act, cur.cnt, cur.fl, cur.dn);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o) begin
            errors++;
            $display("FAIL event_value cyc=%0d got m=%0d note=%0d act=%0d cnt=%0d full=%0d done=%0d, expected m=%0d note=%0d act=%0d cnt=%0d full=%0d done=%0d",
                     cyc, cur.m, cur.nt, cur.act, cur.cnt, cur.fl, cur.dn,
                     e.o.m, e.o.nt, e.o.act, e.o.cnt, e.o.fl, e.o.dn);
          end
          if (e.gap >= 0) begin
            checks++;
            if (cyc - last != e.gap) begin
              errors++;
              $display("FAIL event_timing cyc=%0d got gap=%0d, expected gap=%0d", cyc, cyc - last, e.gap);
            end
          end
        end
        last  = cyc;
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [6:0] nt, input logic act,
                      input logic [2:0] cnt, input logic fl, input logic dn, input int gap);
    exp_t e;
    e.o   = '{m: m, nt: nt, act: act, cnt: cnt, fl: fl, dn: dn};
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; record_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    key_valid = 1'b0; key_ascii = 7'd0;
    push(0, 0, 0, 0, 0, 0, -1);
    #1 reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);

    // Record: A for 12 cycles, silence 8, S 8 -> {65,3},{0,2},{83,2}
    key_valid = 1'b1; key_ascii = 7'd65; record_start = 1'b1;
    push(1, 65, 1, 0, 0, 0, -1);
    step(1); record_start = 1'b0;
    step(12);
    key_valid = 1'b0;
    push(1, 0, 0, 0, 0, 0, 12);
    push(1, 0, 0, 1, 0, 0, 1);
    step(8);
    key_valid = 1'b1; key_ascii = 7'd83;
    push(1, 83, 1, 1, 0, 0, 7);
    push(1, 83, 1, 2, 0, 0, 1);
    step(8);
    stop = 1'b1;
    push(0, 0, 0, 3, 0, 0, 8);
    step(1); stop = 1'b0; key_valid = 1'b0;
    step(3);

    // Full playback
    play_start = 1'b1;
    push(2, 0, 0, 3, 0, 0, -1);
    push(2, 65, 1, 3, 0, 0, 1);
    push(2, 0, 0, 3, 0, 0, 12);
    push(2, 83, 1, 3, 0, 0, 8);
    push(0, 0, 0, 3, 0, 1, 8);
    push(0, 0, 0, 3, 0, 0, 1);
    step(1); play_start = 1'b0;
    step(40);

    // record_start ignored in PLAY, then stop mid-play
    play_start = 1'b1;
    push(2, 0, 0, 3, 0, 0, -1);
    push(2, 65, 1, 3, 0, 0, 1);
    step(1); play_start = 1'b0;
    step(3);
    record_start = 1'b1;
    step(1); record_start = 1'b0;
    step(1);
    stop = 1'b1;
    push(0, 0, 0, 3, 0, 1, 5);
    push(0, 0, 0, 3, 0, 0, 1);
    step(1); stop = 1'b0;
    step(4);

    // Blip of W shorter than a tick between two A segments
    key_valid = 1'b1; key_ascii = 7'd65; record_start = 1'b1;
    push(1, 65, 1, 0, 0, 0, -1);
    step(1); record_start = 1'b0;
    step(7);
    key_ascii = 7'd87;
    push(1, 87, 1, 0, 0, 0, 7);
    push(1, 87, 1, 1, 0, 0, 1);
    step(2);
    key_ascii = 7'd65;
    push(1, 65, 1, 1, 0, 0, 1);
    step(7);
    stop = 1'b1;
    push(0, 0, 0, 2, 0, 0, 8);
    step(1); stop = 1'b0; key_valid = 1'b0;
    step(3);
    play_start = 1'b1;
    push(2, 0, 0, 2, 0, 0, -1);
    push(2, 65, 1, 2, 0, 0, 1);
    push(0, 0, 0, 2, 0, 1, 16);
    push(0, 0, 0, 2, 0, 0, 1);
    step(1); play_start = 1'b0;
    step(25);

    // Fill memory: alternate keys every 4 ticks
    key_valid = 1'b1; key_ascii = 7'd65; record_start = 1'b1;
    push(1, 65, 1, 0, 0, 0, -1);
    step(1); record_start = 1'b0;
    step(16); key_ascii = 7'd83;
    push(1, 83, 1, 0, 0, 0, 16);
    push(1, 83, 1, 1, 0, 0, 1);
    step(16); key_ascii = 7'd65;
    push(1, 65, 1, 1, 0, 0, 15);
    push(1, 65, 1, 2, 0, 0, 1);
    step(16); key_ascii = 7'd83;
    push(1, 83, 1, 2, 0, 0, 15);
    push(1, 83, 1, 3, 0, 0, 1);
    step(16); key_ascii = 7'd65;
    push(1, 65, 1, 3, 0, 0, 15);
    push(0, 0, 0, 4, 1, 0, 1);
    step(5); key_ascii = 7'd87;
    step(3); key_ascii = 7'd65;
    step(2); key_valid = 1'b0;
    step(2);

    // Reset mid-PLAY, then play with empty memory
    play_start = 1'b1;
    push(2, 0, 0, 4, 1, 0, -1);
    push(2, 65, 1, 4, 1, 0, 1);
    step(1); play_start = 1'b0;
    step(4);
    reset = 1'b1;
    push(0, 0, 0, 0, 0, 0, 3);
    step(2); reset = 1'b0;
    step(2);
    play_start = 1'b1;
    push(0, 0, 0, 0, 0, 1, -1);
    push(0, 0, 0, 0, 0, 0, 1);
    step(1); play_start = 1'b0;
    step(3);

    // stop in IDLE does nothing
    stop = 1'b1;
    step(1); stop = 1'b0;
    step(2);

    // Reset mid-RECORD loses the partial recording
    key_valid = 1'b1; key_ascii = 7'd65; record_start = 1'b1;
    push(1, 65, 1, 0, 0, 0, -1);
    step(1); record_start = 1'b0;
    step(3);
    reset = 1'b1;
    push(0, 0, 0, 0, 0, 0, 3);
    step(1); reset = 1'b0; key_valid = 1'b0;
    step(2);
    play_start = 1'b1;
    push(0, 0, 0, 0, 0, 1, -1);
    push(0, 0, 0, 0, 0, 0, 1);
    step(1); play_start = 1'b0;
    step(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d unconsumed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
